// File: rtl/branch_resolve_unit_pkg.sv
// Shared CPU types for the branch execution stage: control word layout,
// funct3 encodings and the record held in the result FIFO.
package cpu_pkg;

    localparam int WIDTH   = 31;
    localparam int ROB     = 2;
    localparam int C_WIDTH = 7;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef struct packed {
        logic [2:0] rsvd;
        logic       jalr;
        logic       jal;
        logic [2:0] funct3;
    } branch_ctrl_t;

    typedef struct packed {
        logic [ROB:0]   rob;
        logic [WIDTH:0] link;
        logic [WIDTH:0] redirect;
        logic           mispredict;
        logic           taken;
        logic [WIDTH:0] pc;
    } branch_result_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// RS-side issue and CDB-side broadcast signals of the branch resolve unit.
interface branch_resolve_unit_if;
    import cpu_pkg::*;

    logic               valid;
    logic               ready;
    logic [WIDTH:0]     src1;
    logic [WIDTH:0]     src2;
    logic [C_WIDTH:0]   instrInfo;
    logic [ROB:0]       instrRob;
    logic [WIDTH:0]     predictedAddress;
    logic [WIDTH:0]     targetAddress;
    logic [WIDTH:0]     fallThrough;
    logic               cdbRequest;
    logic               cdbGrant;
    logic [ROB:0]       cdbRob;
    logic [WIDTH:0]     cdbValue;
    logic               mispredict;
    logic [WIDTH:0]     redirectPC;
    logic               btbUpdate;
    logic [WIDTH:0]     btbPC;
    logic [WIDTH:0]     btbTarget;

    modport master (
        output valid, src1, src2, instrInfo, instrRob, predictedAddress,
               targetAddress, fallThrough, cdbGrant,
        input  ready, cdbRequest, cdbRob, cdbValue, mispredict, redirectPC,
               btbUpdate, btbPC, btbTarget
    );

    modport slave (
        input  valid, src1, src2, instrInfo, instrRob, predictedAddress,
               targetAddress, fallThrough, cdbGrant,
        output ready, cdbRequest, cdbRob, cdbValue, mispredict, redirectPC,
               btbUpdate, btbPC, btbTarget
    );

endinterface

// File: rtl/branch_resolve_unit_compare.sv
// Combinational branch resolution: direction, correct next PC and mispredict.
module branch_compare
    import cpu_pkg::*;
(
    input  logic [WIDTH:0] src1,
    input  logic [WIDTH:0] src2,
    input  branch_ctrl_t   ctrl,
    input  logic [WIDTH:0] target_address,
    input  logic [WIDTH:0] fall_through,
    input  logic [WIDTH:0] predicted_address,
    output logic           taken,
    output logic [WIDTH:0] redirect,
    output logic           mispredict
);

    logic [WIDTH:0] jalr_sum;
    logic [WIDTH:0] target;
    logic           unused_rsvd;

    assign unused_rsvd = ^ctrl.rsvd;
    assign jalr_sum    = src1 + src2;

    always_comb begin
        taken  = 1'b0;
        target = target_address;
        if (ctrl.jalr) begin
            taken  = 1'b1;
            target = {jalr_sum[WIDTH:1], 1'b0};
        end else if (ctrl.jal) begin
            taken  = 1'b1;
        end else begin
            case (ctrl.funct3)
                BEQ:     taken = (src1 == src2);
                BNE:     taken = (src1 != src2);
                BLT:     taken = ($signed(src1) <  $signed(src2));
                BGE:     taken = ($signed(src1) >= $signed(src2));
                BLTU:    taken = (src1 <  src2);
                BGEU:    taken = (src1 >= src2);
                default: taken = 1'b0;
            endcase
        end
    end

    assign redirect   = taken ? target : fall_through;
    assign mispredict = (redirect != predicted_address);

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch execution stage: resolves the issued branch, queues the result and
// broadcasts the FIFO head on the CDB when granted.
module branch_resolve_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 flush,
    branch_resolve_unit_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    branch_result_t   mem_reg [DEPTH];
    branch_result_t   head;
    branch_result_t   res;
    logic [PTR_W-1:0] head_ptr_reg;
    logic [PTR_W-1:0] tail_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             btb_update_reg;
    logic [WIDTH:0]   btb_pc_reg;
    logic [WIDTH:0]   btb_target_reg;
    logic             push;
    logic             pop;
    logic             req;

    branch_compare u_compare (
        .src1              (bus.src1),
        .src2              (bus.src2),
        .ctrl              (branch_ctrl_t'(bus.instrInfo)),
        .target_address    (bus.targetAddress),
        .fall_through      (bus.fallThrough),
        .predicted_address (bus.predictedAddress),
        .taken             (res.taken),
        .redirect          (res.redirect),
        .mispredict        (res.mispredict)
    );

    assign res.rob  = bus.instrRob;
    assign res.link = bus.fallThrough;
    assign res.pc   = bus.fallThrough - 32'd4;

    assign req       = (count_reg != '0);
    assign bus.ready = (count_reg < FULL_COUNT) || bus.cdbGrant;
    assign push      = bus.valid && bus.ready && !flush;
    assign pop       = bus.cdbGrant && req && !flush;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset; the head outputs are masked whenever the FIFO is empty.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (tail_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= res;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear || flush) begin
            head_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            count_reg    <= '0;
        end else begin
            if (push) tail_ptr_reg <= tail_ptr_reg + 1'b1;
            if (pop)  head_ptr_reg <= head_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Flush does not cancel the BTB write of an entry popped on the prior cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            btb_update_reg <= 1'b0;
            btb_pc_reg     <= '0;
            btb_target_reg <= '0;
        end else begin
            btb_update_reg <= pop && head.taken;
            if (pop) begin
                btb_pc_reg     <= head.pc;
                btb_target_reg <= head.redirect;
            end
        end
    end

    assign head           = mem_reg[head_ptr_reg];
    assign bus.cdbRequest = req;
    assign bus.cdbRob     = req ? head.rob        : '0;
    assign bus.cdbValue   = req ? head.link       : '0;
    assign bus.redirectPC = req ? head.redirect   : '0;
    assign bus.mispredict = req && head.mispredict;
    assign bus.btbUpdate  = btb_update_reg;
    assign bus.btbPC      = btb_pc_reg;
    assign bus.btbTarget  = btb_target_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a resolve vector table plus
// hand-written backpressure, flush and clear sequences.
module tb_branch_resolve_unit;

    logic clk;
    logic clear;
    logic flush;
    int   n_cmp;
    int   n_bad;

    branch_resolve_unit_if bus ();

    branch_resolve_unit dut (
        .clk   (clk),
        .clear (clear),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [7:0]  info;
        logic [2:0]  rob;
        logic [31:0] pred;
        logic [31:0] tgt;
        logic [31:0] ft;
        logic        exp_mis;
        logic        exp_tk;
        logic [31:0] exp_red;
        logic [31:0] exp_bpc;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [2:0] rob);
        bus.valid            = 1'b1;
        bus.src1             = v.s1;
        bus.src2             = v.s2;
        bus.instrInfo        = v.info;
        bus.instrRob         = rob;
        bus.predictedAddress = v.pred;
        bus.targetAddress    = v.tgt;
        bus.fallThrough      = v.ft;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //         s1            s2            info   rob   pred          tgt           ft            mis   tk    red           bpc
        vecs[0] = '{32'd5,        32'd5,        8'h00, 3'd1, 32'h100,      32'h100,      32'h24,       1'b0, 1'b1, 32'h100,      32'h20};
        vecs[1] = '{32'hFFFFFFFF, 32'd1,        8'h04, 3'd2, 32'h44,       32'h200,      32'h44,       1'b1, 1'b1, 32'h200,      32'h40};
        vecs[2] = '{32'hFFFFFFFF, 32'd1,        8'h06, 3'd3, 32'h44,       32'h200,      32'h44,       1'b0, 1'b0, 32'h44,       32'h40};
        vecs[3] = '{32'h1003,     32'd2,        8'h10, 3'd4, 32'h80,       32'h999,      32'h80,       1'b1, 1'b1, 32'h1004,     32'h7C};
        vecs[4] = '{32'd3,        32'd3,        8'h01, 3'd5, 32'h300,      32'h300,      32'h30,       1'b1, 1'b0, 32'h30,       32'h2C};
        vecs[5] = '{32'hFFFFFFFE, 32'hFFFFFFFD, 8'h05, 3'd6, 32'h400,      32'h400,      32'h50,       1'b0, 1'b1, 32'h400,      32'h4C};
        vecs[6] = '{32'd1,        32'hFFFFFFFF, 8'h07, 3'd7, 32'h60,       32'h600,      32'h60,       1'b0, 1'b0, 32'h60,       32'h5C};
        vecs[7] = '{32'd9,        32'd9,        8'h02, 3'd0, 32'h500,      32'h500,      32'h70,       1'b1, 1'b0, 32'h70,       32'h6C};
        vecs[8] = '{32'd0,        32'd1,        8'hE8, 3'd1, 32'h10,       32'h800,      32'h10,       1'b1, 1'b1, 32'h800,      32'hC};
        vecs[9] = '{32'hFFFFFFFF, 32'd3,        8'h10, 3'd2, 32'h2,        32'h900,      32'h90,       1'b0, 1'b1, 32'h2,        32'h8C};

        clear = 1'b1;
        flush = 1'b0;
        bus.valid = 1'b0;
        bus.cdbGrant = 1'b0;
        bus.src1 = '0; bus.src2 = '0; bus.instrInfo = '0; bus.instrRob = '0;
        bus.predictedAddress = '0; bus.targetAddress = '0; bus.fallThrough = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_req", 32'(bus.cdbRequest), 32'd0);
        chk("rst_mis", 32'(bus.mispredict), 32'd0);
        chk("rst_btbu", 32'(bus.btbUpdate), 32'd0);
        chk("rst_rob", 32'(bus.cdbRob), 32'd0);
        chk("rst_btbpc", bus.btbPC, 32'd0);
        $display("reset: ready=%0d req=%0d", bus.ready, bus.cdbRequest);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i], vecs[i].rob);
            @(negedge clk);
            bus.valid = 1'b0;
            #1;
            chk($sformatf("v%0d_req", i), 32'(bus.cdbRequest), 32'd1);
            chk($sformatf("v%0d_rob", i), 32'(bus.cdbRob), 32'(vecs[i].rob));
            chk($sformatf("v%0d_value", i), bus.cdbValue, vecs[i].ft);
            chk($sformatf("v%0d_mis", i), 32'(bus.mispredict), 32'(vecs[i].exp_mis));
            chk($sformatf("v%0d_redirect", i), bus.redirectPC, vecs[i].exp_red);
            bus.cdbGrant = 1'b1;
            @(negedge clk);
            bus.cdbGrant = 1'b0;
            #1;
            chk($sformatf("v%0d_btbu", i), 32'(bus.btbUpdate), 32'(vecs[i].exp_tk));
            chk($sformatf("v%0d_btbpc", i), bus.btbPC, vecs[i].exp_bpc);
            chk($sformatf("v%0d_btbtgt", i), bus.btbTarget, vecs[i].exp_red);
            chk($sformatf("v%0d_req_after", i), 32'(bus.cdbRequest), 32'd0);
            $display("vec %0d: info=0x%0h redirect=0x%0h mis=%0d btbu=%0d",
                     i, vecs[i].info, vecs[i].exp_red, vecs[i].exp_mis, vecs[i].exp_tk);
        end

        // Backpressure: third push waits for grant; tags pop in order.
        @(negedge clk);
        drive(vecs[0], 3'd1);
        #1 chk("bp_ready1", 32'(bus.ready), 32'd1);
        @(negedge clk);
        drive(vecs[0], 3'd2);
        #1 chk("bp_ready2", 32'(bus.ready), 32'd1);
        @(negedge clk);
        drive(vecs[0], 3'd3);
        #1 chk("bp_ready3", 32'(bus.ready), 32'd0);
        @(negedge clk);
        #1 chk("bp_stall", 32'(bus.ready), 32'd0);
        chk("bp_head1", 32'(bus.cdbRob), 32'd1);
        bus.cdbGrant = 1'b1;
        #1 chk("bp_ready_grant", 32'(bus.ready), 32'd1);
        @(negedge clk);
        bus.valid = 1'b0;
        #1 chk("bp_head2", 32'(bus.cdbRob), 32'd2);
        @(negedge clk);
        #1 chk("bp_head3", 32'(bus.cdbRob), 32'd3);
        @(negedge clk);
        bus.cdbGrant = 1'b0;
        #1 chk("bp_empty", 32'(bus.cdbRequest), 32'd0);
        $display("backpressure: three tags popped in order");

        // Flush while full, with a same-cycle push and grant.
        @(negedge clk);
        drive(vecs[0], 3'd4);
        @(negedge clk);
        drive(vecs[0], 3'd5);
        @(negedge clk);
        drive(vecs[0], 3'd6);
        #1 chk("fl_full", 32'(bus.ready), 32'd0);
        bus.cdbGrant = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.valid = 1'b0;
        bus.cdbGrant = 1'b0;
        #1;
        chk("fl_req", 32'(bus.cdbRequest), 32'd0);
        chk("fl_ready", 32'(bus.ready), 32'd1);
        chk("fl_btbu", 32'(bus.btbUpdate), 32'd0);
        @(negedge clk);
        #1 chk("fl_req_later", 32'(bus.cdbRequest), 32'd0);
        $display("flush: fifo emptied, nothing broadcast");

        // Clear with two entries queued, then a normal transaction.
        @(negedge clk);
        drive(vecs[3], 3'd2);
        @(negedge clk);
        drive(vecs[1], 3'd3);
        @(negedge clk);
        bus.valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clr_req", 32'(bus.cdbRequest), 32'd0);
        chk("clr_mis", 32'(bus.mispredict), 32'd0);
        chk("clr_rob", 32'(bus.cdbRob), 32'd0);
        chk("clr_value", bus.cdbValue, 32'd0);
        chk("clr_redirect", bus.redirectPC, 32'd0);
        chk("clr_btbu", 32'(bus.btbUpdate), 32'd0);
        chk("clr_btbpc", bus.btbPC, 32'd0);
        chk("clr_btbtgt", bus.btbTarget, 32'd0);
        chk("clr_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        drive(vecs[4], 3'd7);
        @(negedge clk);
        bus.valid = 1'b0;
        #1;
        chk("post_req", 32'(bus.cdbRequest), 32'd1);
        chk("post_rob", 32'(bus.cdbRob), 32'd7);
        chk("post_redirect", bus.redirectPC, 32'h30);
        bus.cdbGrant = 1'b1;
        @(negedge clk);
        bus.cdbGrant = 1'b0;
        #1;
        chk("post_btbpc", bus.btbPC, 32'h2C);
        chk("post_empty", 32'(bus.cdbRequest), 32'd0);
        $display("clear: outputs zeroed, next push broadcast");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
